sd_page_arbiter: RTL

- Shares one SD-backed paged ROM port (24-bit address, byte data, enable/busy handshake) between two requesters: port 0 (instruction fetch) and port 1 (data read).
- Sits between the W65C832 core's memory decode and the SD paging block.
- Per grant, it issues one byte access, holds enable through any sector fill, captures the byte, and acknowledges the winning requester.
- Fairness between the two ports is round-robin.

---
 rtl/sd_page_arb_pkg.sv | 16 +
 rtl/sd_page_arbiter_if.sv | 37 +++
 rtl/rr_pick2.sv | 10 +
 rtl/sd_page_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/sd_page_arb_pkg.sv
// Shared encodings and constants for the SD paged-ROM arbiter family.
package sd_page_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int NUM_REQ = 2;

    // Byte returned to a requester when the paging block never finishes.
    localparam logic [7:0] TIMEOUT_FILL = 8'hff;

endpackage

// File: rtl/sd_page_arbiter_if.sv
// Requester and paging-block signals of the SD page arbiter, bundled as one interface.
interface sd_page_arbiter_if #(
    parameter int ADDR_WIDTH = 24
);
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_address;
    logic                  req0_ack;
    logic [7:0]            req0_data;

    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_address;
    logic                  req1_ack;
    logic [7:0]            req1_data;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_enable;
    logic                  mem_busy;
    logic [7:0]            mem_data;

    logic                  error;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_address, req1_valid, req1_address,
        input  mem_busy, mem_data,
        output req0_ack, req0_data, req1_ack, req1_data,
        output mem_address, mem_enable, error
    );

    // Requesters plus paging block, as seen from outside the arbiter.
    modport master (
        output req0_valid, req0_address, req1_valid, req1_address,
        output mem_busy, mem_data,
        input  req0_ack, req0_data, req1_ack, req1_data,
        input  mem_address, mem_enable, error
    );
endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone valid wins, a tie goes to the port not granted last.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);
    assign grant_valid = |valid;
    assign grant_id    = (valid == 2'b11) ? ~last_grant : valid[1];
endmodule

// File: rtl/sd_page_arbiter.sv
// Round-robin arbiter sharing one SD-backed paged ROM byte port between fetch and data reads.
// Optional watchdog in WAIT is enabled with `define SD_PAGE_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no access in flight; pick a requester
// ISSUE | enable just raised; paging block outputs still stale
// WAIT  | enable held until the paging block reports not busy
// DONE  | ack pulse to the granted port; requester drops valid
module sd_page_arbiter
    import sd_page_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 24,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic              clk,
    input  logic              reset,
    sd_page_arbiter_if.slave  bus
);
    arb_state_t            state_q, state_d;
    logic                  grant_id_q, grant_id_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic                  mem_enable_q, mem_enable_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [7:0]            data0_q, data0_d;
    logic [7:0]            data1_q, data1_d;
    logic [7:0]            wait_byte;
    logic [NUM_REQ-1:0]    req_valid;
    logic                  pick_valid;
    logic                  pick_id;
    logic                  wait_timeout;

    assign req_valid = {bus.req1_valid, bus.req0_valid};

    rr_pick2 u_pick (
        .valid       (req_valid),
        .last_grant  (last_grant_q),
        .grant_valid (pick_valid),
        .grant_id    (pick_id)
    );

`ifdef SD_PAGE_ARB_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] timer_q;
    logic               error_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
            error_q <= 1'b0;
        end else begin
            error_q <= wait_timeout;
            if (state_q == ST_ISSUE) begin
                timer_q <= '0;
            end else if (state_q == ST_WAIT) begin
                timer_q <= timer_q + TIMER_W'(1);
            end
        end
    end

    // Fires on the WAIT cycle that completes TIMEOUT_CYCLES cycles of waiting.
    assign wait_timeout = (state_q == ST_WAIT) && bus.mem_busy && (timer_q == TIMER_LAST);
    assign bus.error    = error_q;
`else
    assign wait_timeout = 1'b0;
    assign bus.error    = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        mem_address_d = mem_address_q;
        mem_enable_d  = mem_enable_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        data0_d       = data0_q;
        data1_d       = data1_q;
        wait_byte     = bus.mem_data;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_id_d    = pick_id;
                    last_grant_d  = pick_id;
                    mem_address_d = pick_id ? bus.req1_address : bus.req0_address;
                    mem_enable_d  = 1'b1;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Enable must stay high here: the paging block only fills while enabled.
                if (!bus.mem_busy || wait_timeout) begin
                    wait_byte = wait_timeout ? TIMEOUT_FILL : bus.mem_data;
                    if (grant_id_q) begin
                        data1_d = wait_byte;
                        ack1_d  = 1'b1;
                    end else begin
                        data0_d = wait_byte;
                        ack0_d  = 1'b1;
                    end
                    mem_enable_d = 1'b0;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_id_q    <= 1'b0;
            last_grant_q  <= 1'b1;
            mem_address_q <= '0;
            mem_enable_q  <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            data0_q       <= '0;
            data1_q       <= '0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            mem_address_q <= mem_address_d;
            mem_enable_q  <= mem_enable_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            data0_q       <= data0_d;
            data1_q       <= data1_d;
        end
    end

    assign bus.req0_ack    = ack0_q;
    assign bus.req0_data   = data0_q;
    assign bus.req1_ack    = ack1_q;
    assign bus.req1_data   = data1_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_enable  = mem_enable_q;
endmodule
